multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multicycle MIPS datapath: one shared memory port, one ALU, and IR/A/B/ALUOut holding registers.
//  Decodes opcode/funct and steps each instruction through FETCH..WRITEBACK, driving every mux select and write strobe.
//  Handshakes with memory (req/ready) with a bounded wait; traps on illegal opcode or memory timeout.
// PARAMETERS
//  WAIT_TIMEOUT  255  max cycles mem_req may stay high without mem_ready before bus_error trap (1..2^TIMEOUT_W-1)
//  TIMEOUT_W     8    width of the wait counter
// PORTS
//  clock        in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  funct        in   6  IR[5:0]
//  zero_flag    in   1  ALU zero, combinational from current-cycle operands
//  mem_ready    in   1  memory completes the access this cycle
//  mem_req      out  1  memory access request, held until mem_ready
//  mem_write    out  1  write access (valid with mem_req)
//  i_or_d       out  1  address select: 0=PC, 1=ALUOut
//  ir_write     out  1  load IR from read data
//  pc_write     out  1  load PC
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
//  alu_control  out  2  00=ADD, 01=SUB, 10=AND, 11=OR
//  reg_write    out  1  register file write enable
//  reg_dest     out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=memory data
//  instr_done   out  1  one-cycle pulse on the last cycle of each retired instruction
//  illegal_op   out  1  sticky: undecodable opcode/funct
//  bus_error    out  1  sticky: memory wait timeout
//  state_dbg    out  4  current state encoding (below)
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0, illegal_op=bus_error=0. All outputs 0 while reset is high (strobes gated by reset).
//  - Outputs are a decode of state; pc_write/ir_write also use mem_ready/zero_flag. Unlisted outputs are 0.
//  - States (state_dbg): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 REX=6 RWB=7 BEQ=8 AEX=9 AWB=10 JMP=11 TRAP=15.
//  - FETCH: mem_req, i_or_d=0, src_a=0, src_b=01, ADD, pc_src=00; ir_write=pc_write=mem_ready; ->DECODE on mem_ready.
//  - DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next by opcode: 0x00->REX,
//    0x23/0x2B->MEMADR, 0x04->BEQ, 0x08->AEX, 0x02->JMP, otherwise set illegal_op ->TRAP.
//  - MEMADR: src_a=1, src_b=10, ADD; ->MEMRD if opcode 0x23, else ->MEMWR.
//  - MEMRD: mem_req, i_or_d=1; ->MEMWB on mem_ready. MEMWB: reg_write, reg_dest=0, mem_to_reg=1, instr_done; ->FETCH.
//  - MEMWR: mem_req, mem_write, i_or_d=1; on mem_ready pulse instr_done, ->FETCH.
//  - REX: src_a=1, src_b=00; funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR; other funct -> illegal_op, TRAP (no write).
//  - RWB: reg_write, reg_dest=1, mem_to_reg=0, same alu_control as REX, instr_done; ->FETCH.
//  - BEQ: src_a=1, src_b=00, SUB, pc_src=01, pc_write=zero_flag, instr_done; ->FETCH.
//  - AEX: src_a=1, src_b=10, ADD; ->AWB. AWB: reg_write, reg_dest=0, mem_to_reg=0, instr_done; ->FETCH.
//  - JMP: pc_src=10, pc_write=1, instr_done; ->FETCH.
//  - TRAP: all strobes 0, holds until reset; sticky flags stay set.
//  - Latency with zero wait: beq/j 3 cycles, R/addi/sw 4, lw 5; each mem wait cycle adds 1.
//  - Wait counter: clears on entry to any mem state and on mem_ready; increments each cycle mem_req=1 & mem_ready=0;
//    at count==WAIT_TIMEOUT with mem_ready=0: bus_error=1, ->TRAP, no strobe that cycle. mem_ready on that same cycle wins.
//  - mem_req/mem_write/i_or_d stay stable for the whole wait; mem_ready outside mem states is ignored.
//  - Reset mid-instruction: abort immediately, back to FETCH, no partial writes after reset asserts.
// TESTING
//  - add (op 0x00, funct 0x20), mem_ready=1 each fetch -> states 0,1,6,7; reg_write+reg_dest=1 in cycle 4, instr_done once.
//  - lw (0x23) with 3 wait cycles in MEMRD -> 8 cycles total; mem_req, i_or_d=1 steady for 4 cycles; then MEMWB mem_to_reg=1.
//  - beq (0x04) zero_flag=1 -> pc_write=1, pc_src=01 in BEQ; repeat with zero_flag=0 -> pc_write=0, still instr_done.
//  - opcode 0x3F -> DECODE->TRAP, illegal_op=1 sticky, all strobes 0 for 20 cycles; reset clears to FETCH.
//  - WAIT_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error=1 after 4 wait cycles, ir_write/pc_write never pulse.
//  - Assert reset in AWB of addi -> reg_write drops same cycle (async), state_dbg=0 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle MIPS datapath: steps each instruction through
// FETCH..WRITEBACK and drives every mux select and write strobe of the shared datapath.
module multicycle_controller #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int TIMEOUT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_AEX    = 4'd9,
    S_AWB    = 4'd10,
    S_JMP    = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOr  = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBBranch = 2'b11;

  localparam logic [TIMEOUT_W-1:0] TimeoutCount = TIMEOUT_W'(WAIT_TIMEOUT);

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_illegal_op;
  logic                 r_bus_error;

  logic       w_in_mem;
  logic       w_timeout;
  logic       w_funct_ok;
  logic [1:0] w_funct_alu;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = AluAdd;
    case (funct)
      FnAdd:   w_funct_alu = AluAdd;
      FnSub:   w_funct_alu = AluSub;
      FnAnd:   w_funct_alu = AluAnd;
      FnOr:    w_funct_alu = AluOr;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  // mem_ready on the timeout cycle still completes the access
  assign w_in_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = w_in_mem && !mem_ready && (r_wait_cnt == TimeoutCount);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_illegal_op <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      if (w_in_mem && !mem_ready && !w_timeout)
        r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      else
        r_wait_cnt <= '0;

      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_state     <= S_TRAP;
          end
        end
        S_DECODE: begin
          case (opcode)
            OpRtype:    r_state <= S_REX;
            OpLw, OpSw: r_state <= S_MEMADR;
            OpBeq:      r_state <= S_BEQ;
            OpAddi:     r_state <= S_AEX;
            OpJ:        r_state <= S_JMP;
            default: begin
              r_illegal_op <= 1'b1;
              r_state      <= S_TRAP;
            end
          endcase
        end
        S_MEMADR: r_state <= (opcode == OpLw) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (mem_ready) begin
            r_state <= S_MEMWB;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_state     <= S_TRAP;
          end
        end
        S_MEMWB: r_state <= S_FETCH;
        S_MEMWR: begin
          if (mem_ready) begin
            r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_state     <= S_TRAP;
          end
        end
        S_REX: begin
          if (w_funct_ok) begin
            r_state <= S_RWB;
          end else begin
            r_illegal_op <= 1'b1;
            r_state      <= S_TRAP;
          end
        end
        S_RWB:   r_state <= S_FETCH;
        S_BEQ:   r_state <= S_FETCH;
        S_AEX:   r_state <= S_AWB;
        S_AWB:   r_state <= S_FETCH;
        S_JMP:   r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Strobes are a decode of the current state, forced low while reset is high
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PcSrcAlu;
    alu_src_a   = 1'b0;
    alu_src_b   = SrcBReg;
    alu_control = AluAdd;
    reg_write   = 1'b0;
    reg_dest    = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SrcBFour;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SrcBBranch;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_REX: begin
          alu_src_a   = 1'b1;
          alu_control = w_funct_alu;
        end
        S_RWB: begin
          reg_write   = 1'b1;
          reg_dest    = 1'b1;
          alu_control = w_funct_alu;
          instr_done  = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 1'b1;
          alu_control = AluSub;
          pc_src      = PcSrcAluOut;
          pc_write    = zero_flag;
          instr_done  = 1'b1;
        end
        S_AEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        S_AWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JMP: begin
          pc_src     = PcSrcJump;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal_op = r_illegal_op;
  assign bus_error  = r_bus_error;
  assign state_dbg  = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares state and the full strobe bundle against hand-derived values.
module tb_multicycle_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zeroFlag;
  logic       memReady;
  logic       memReq, memWrite, iOrD, irWrite, pcWrite;
  logic [1:0] pcSrc;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluControl;
  logic       regWrite, regDest, memToReg, instrDone;
  logic       illegalOp, busError;
  logic [3:0] stateDbg;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] obs;
  logic [15:0] oZero, oFetchRdy, oFetchWait, oDecode, oMemadr, oMemrd, oMemwb;
  logic [15:0] oMemwrWait, oMemwrRdy, oRexAdd, oRwbAdd, oBeqTaken, oBeqNot;
  logic [15:0] oAex, oAwb, oJmp;

  multicycle_controller #(.WAIT_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero_flag(zeroFlag), .mem_ready(memReady),
    .mem_req(memReq), .mem_write(memWrite), .i_or_d(iOrD), .ir_write(irWrite),
    .pc_write(pcWrite), .pc_src(pcSrc), .alu_src_a(aluSrcA), .alu_src_b(aluSrcB),
    .alu_control(aluControl), .reg_write(regWrite), .reg_dest(regDest),
    .mem_to_reg(memToReg), .instr_done(instrDone), .illegal_op(illegalOp),
    .bus_error(busError), .state_dbg(stateDbg)
  );

  always #5 clock = ~clock;

  assign obs = {memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
                aluControl, regWrite, regDest, memToReg, instrDone};

  function automatic logic [15:0] ov(input logic req, wr, iord, irw, pcw,
                                     input logic [1:0] pcs, input logic srca,
                                     input logic [1:0] srcb, aluc,
                                     input logic rw, rd, m2r, done);
    return {req, wr, iord, irw, pcw, pcs, srca, srcb, aluc, rw, rd, m2r, done};
  endfunction

  task automatic initExpected();
    oZero      = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    oFetchRdy  = ov(1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    oFetchWait = ov(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    oDecode    = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    oMemadr    = ov(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    oMemrd     = ov(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    oMemwb     = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 1);
    oMemwrWait = ov(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    oMemwrRdy  = ov(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    oRexAdd    = ov(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    oRwbAdd    = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    oBeqTaken  = ov(0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 1);
    oBeqNot    = ov(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 1);
    oAex       = ov(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    oAwb       = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    oJmp       = ov(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 1);
  endtask

  // Leaves reset released on a falling edge, with the DUT in FETCH for the coming cycle
  task automatic doReset();
    reset    = 1'b1;
    memReady = 1'b0;
    zeroFlag = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b1; zeroFlag = 1'b1; opcode = 6'h23; funct = 6'h20;
    repeat (2) @(negedge clock);
    #1;
    checkCount++;
    if (obs !== oZero) begin
      errorCount++; $display("[TB] FAIL reset_strobes: got %h, expected %h", obs, oZero);
    end
    checkCount++;
    if ({stateDbg, illegalOp, busError} !== 6'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_state: got state=%0d ill=%b bus=%b, expected 0 0 0",
               stateDbg, illegalOp, busError);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkCount++;
    if (stateDbg !== 4'd0 || obs !== oFetchRdy) begin
      errorCount++;
      $display("[TB] FAIL reset_release: got state=%0d out=%h, expected 0 %h", stateDbg, obs, oFetchRdy);
    end
  endtask

  task automatic test_add();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    bit          rdy [5] = '{1, 1, 1, 1, 0};
    logic [15:0] eo [5];
    eo = '{oFetchRdy, oDecode, oRexAdd, oRwbAdd, oFetchWait};
    doReset();
    opcode = 6'h00; funct = 6'h20;
    for (int c = 0; c < 5; c++) begin
      memReady = rdy[c];
      #1;
      checkCount++;
      if (stateDbg !== es[c]) begin
        errorCount++; $display("[TB] FAIL add_state cyc%0d: got %0d, expected %0d", c, stateDbg, es[c]);
      end
      checkCount++;
      if (obs !== eo[c]) begin
        errorCount++; $display("[TB] FAIL add_out cyc%0d: got %h, expected %h", c, obs, eo[c]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  es [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    bit          rdy [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [15:0] eo [9];
    eo = '{oFetchRdy, oDecode, oMemadr, oMemrd, oMemrd, oMemrd, oMemrd, oMemwb, oFetchWait};
    doReset();
    opcode = 6'h23; funct = 6'h00;
    for (int c = 0; c < 9; c++) begin
      memReady = rdy[c];
      #1;
      checkCount++;
      if (stateDbg !== es[c]) begin
        errorCount++; $display("[TB] FAIL lw_state cyc%0d: got %0d, expected %0d", c, stateDbg, es[c]);
      end
      checkCount++;
      if (obs !== eo[c]) begin
        errorCount++; $display("[TB] FAIL lw_out cyc%0d: got %h, expected %h", c, obs, eo[c]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    bit          rdy [6] = '{1, 0, 0, 0, 1, 0};
    logic [15:0] eo [6];
    eo = '{oFetchRdy, oDecode, oMemadr, oMemwrWait, oMemwrRdy, oFetchWait};
    doReset();
    opcode = 6'h2B; funct = 6'h00;
    for (int c = 0; c < 6; c++) begin
      memReady = rdy[c];
      #1;
      checkCount++;
      if (stateDbg !== es[c]) begin
        errorCount++; $display("[TB] FAIL sw_state cyc%0d: got %0d, expected %0d", c, stateDbg, es[c]);
      end
      checkCount++;
      if (obs !== eo[c]) begin
        errorCount++; $display("[TB] FAIL sw_out cyc%0d: got %h, expected %h", c, obs, eo[c]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_beq(input bit z);
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    bit          rdy [4] = '{1, 0, 0, 0};
    logic [15:0] eo [4];
    eo = '{oFetchRdy, oDecode, z ? oBeqTaken : oBeqNot, oFetchWait};
    doReset();
    opcode = 6'h04; funct = 6'h00; zeroFlag = z;
    for (int c = 0; c < 4; c++) begin
      memReady = rdy[c];
      #1;
      checkCount++;
      if (stateDbg !== es[c]) begin
        errorCount++; $display("[TB] FAIL beq_z%0d_state cyc%0d: got %0d, expected %0d", z, c, stateDbg, es[c]);
      end
      checkCount++;
      if (obs !== eo[c]) begin
        errorCount++; $display("[TB] FAIL beq_z%0d_out cyc%0d: got %h, expected %h", z, c, obs, eo[c]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    bit          rdy [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    logic [5:0]  op [8] = '{6'h02, 6'h02, 6'h02, 6'h08, 6'h08, 6'h08, 6'h08, 6'h08};
    logic [15:0] eo [8];
    eo = '{oFetchRdy, oDecode, oJmp, oFetchRdy, oDecode, oAex, oAwb, oFetchWait};
    doReset();
    funct = 6'h00;
    for (int c = 0; c < 8; c++) begin
      memReady = rdy[c];
      opcode   = op[c];
      #1;
      checkCount++;
      if (stateDbg !== es[c]) begin
        errorCount++; $display("[TB] FAIL b2b_state cyc%0d: got %0d, expected %0d", c, stateDbg, es[c]);
      end
      checkCount++;
      if (obs !== eo[c]) begin
        errorCount++; $display("[TB] FAIL b2b_out cyc%0d: got %h, expected %h", c, obs, eo[c]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_illegal_opcode();
    doReset();
    opcode = 6'h3F; funct = 6'h20;
    memReady = 1'b1;
    @(negedge clock);
    memReady = 1'b0;
    #1;
    checkCount++;
    if (stateDbg !== 4'd1 || illegalOp !== 1'b0) begin
      errorCount++; $display("[TB] FAIL illop_decode: got state=%0d ill=%b, expected 1 0", stateDbg, illegalOp);
    end
    @(negedge clock);
    for (int c = 0; c < 20; c++) begin
      memReady = c[0];
      #1;
      checkCount++;
      if (stateDbg !== 4'd15 || obs !== oZero || illegalOp !== 1'b1 || busError !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL illop_trap cyc%0d: got state=%0d out=%h ill=%b bus=%b, expected 15 %h 1 0",
                 c, stateDbg, obs, illegalOp, busError, oZero);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    checkCount++;
    if (stateDbg !== 4'd0 || illegalOp !== 1'b0) begin
      errorCount++; $display("[TB] FAIL illop_clear: got state=%0d ill=%b, expected 0 0", stateDbg, illegalOp);
    end
    @(negedge clock);
    reset = 1'b0; memReady = 1'b0;
    #1;
    checkCount++;
    if (stateDbg !== 4'd0 || obs !== oFetchWait) begin
      errorCount++; $display("[TB] FAIL illop_refetch: got state=%0d out=%h, expected 0 %h", stateDbg, obs, oFetchWait);
    end
  endtask

  task automatic test_illegal_funct();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd15};
    bit          rdy [4] = '{1, 0, 0, 0};
    logic [15:0] eo [4];
    eo = '{oFetchRdy, oDecode, oRexAdd, oZero};
    doReset();
    opcode = 6'h00; funct = 6'h2A;
    for (int c = 0; c < 4; c++) begin
      memReady = rdy[c];
      #1;
      checkCount++;
      if (stateDbg !== es[c]) begin
        errorCount++; $display("[TB] FAIL badfn_state cyc%0d: got %0d, expected %0d", c, stateDbg, es[c]);
      end
      checkCount++;
      if (obs !== eo[c]) begin
        errorCount++; $display("[TB] FAIL badfn_out cyc%0d: got %h, expected %h", c, obs, eo[c]);
      end
      @(negedge clock);
    end
    #1;
    checkCount++;
    if (illegalOp !== 1'b1 || busError !== 1'b0) begin
      errorCount++; $display("[TB] FAIL badfn_flags: got ill=%b bus=%b, expected 1 0", illegalOp, busError);
    end
  endtask

  // Count reaches 4 after four idle cycles; the fifth cycle is the decision cycle
  task automatic test_timeout(input bit readyOnLast);
    doReset();
    opcode = 6'h00; funct = 6'h20;
    for (int c = 0; c < 5; c++) begin
      memReady = (c == 4) ? readyOnLast : 1'b0;
      #1;
      checkCount++;
      if (stateDbg !== 4'd0 || obs !== ((c == 4 && readyOnLast) ? oFetchRdy : oFetchWait)) begin
        errorCount++;
        $display("[TB] FAIL timeout_r%0d_fetch cyc%0d: got state=%0d out=%h", readyOnLast, c, stateDbg, obs);
      end
      @(negedge clock);
    end
    memReady = 1'b1;
    #1;
    checkCount++;
    if (readyOnLast) begin
      if (stateDbg !== 4'd1 || busError !== 1'b0) begin
        errorCount++; $display("[TB] FAIL timeout_edge: got state=%0d bus=%b, expected 1 0", stateDbg, busError);
      end
    end else begin
      if (stateDbg !== 4'd15 || busError !== 1'b1 || illegalOp !== 1'b0 || obs !== oZero) begin
        errorCount++;
        $display("[TB] FAIL timeout_trap: got state=%0d bus=%b ill=%b out=%h, expected 15 1 0 %h",
                 stateDbg, busError, illegalOp, obs, oZero);
      end
      repeat (3) @(negedge clock);
      #1;
      checkCount++;
      if (stateDbg !== 4'd15 || busError !== 1'b1 || obs !== oZero) begin
        errorCount++; $display("[TB] FAIL timeout_hold: got state=%0d bus=%b out=%h, expected 15 1 0", stateDbg, busError, obs);
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    opcode = 6'h08; funct = 6'h00;
    memReady = 1'b1;
    @(negedge clock);
    memReady = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checkCount++;
    if (stateDbg !== 4'd10 || regWrite !== 1'b1) begin
      errorCount++; $display("[TB] FAIL rstmid_awb: got state=%0d rw=%b, expected 10 1", stateDbg, regWrite);
    end
    reset = 1'b1;
    #1;
    checkCount++;
    if (regWrite !== 1'b0 || obs !== oZero || stateDbg !== 4'd0) begin
      errorCount++; $display("[TB] FAIL rstmid_async: got rw=%b out=%h state=%0d, expected 0 %h 0", regWrite, obs, stateDbg, oZero);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkCount++;
    if (stateDbg !== 4'd0 || obs !== oFetchWait) begin
      errorCount++; $display("[TB] FAIL rstmid_release: got state=%0d out=%h, expected 0 %h", stateDbg, obs, oFetchWait);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; memReady = 1'b0; zeroFlag = 1'b0; opcode = 6'h00; funct = 6'h00;
    initExpected();
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_back_to_back();
    test_illegal_opcode();
    test_illegal_funct();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
